// File: rtl/controlador_display.sv
`default_nettype none
// ============================================================================
// Module      : controlador_display
// Description : Time-multiplexed scan controller for a 4-digit 7-segment
//               display sharing one external BCD-to-segment encoder. Holds a
//               double-buffered packed-BCD value that swaps in only at frame
//               boundaries, with leading-zero and invalid-digit suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_display #(
    parameter int DIVISOR = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] valor,
    input  logic        blank_zeros,
    output logic [3:0]  BCD,
    input  logic [6:0]  DISPLAY,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        ack,
    output logic        erro
);

    localparam int              c_cnt_w    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIVISOR - 1);

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_d;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic [15:0]        r_ativo;
    logic [15:0]        r_sombra;
    logic               r_pendente;
    logic               r_ack;
    logic               r_erro;

    logic [3:0]  w_digit;
    logic        w_upper_zero;
    logic        w_suppress;
    logic        w_boundary;
    logic        w_apply;
    logic [15:0] w_next_ativo;
    logic        w_next_erro;

    // Current digit nibble goes straight to the shared encoder; it only changes
    // when the digit index or the active value changes, i.e. at slot ends.
    assign w_digit = r_ativo[{r_d, 2'b00} +: 4];
    assign BCD     = w_digit;

    // Current digit and every higher digit are zero (digit 0 is never blanked)
    always_comb begin
        w_upper_zero = 1'b0;
        case (r_d)
            2'd1:    w_upper_zero = (r_ativo[15:4]  == 12'h000);
            2'd2:    w_upper_zero = (r_ativo[15:8]  == 8'h00);
            2'd3:    w_upper_zero = (r_ativo[15:12] == 4'h0);
            default: w_upper_zero = 1'b0;
        endcase
    end

    assign w_suppress = (w_digit > 4'd9) || (blank_zeros && w_upper_zero);

    // Frame boundary is the edge that ends the last SHOW cycle of digit 3
    assign w_boundary   = (r_state == c_st_show) && (r_cnt == c_cnt_last) && (r_d == 2'd3);
    // A load on the boundary edge bypasses the shadow register
    assign w_next_ativo = load ? valor : r_sombra;
    assign w_apply      = w_boundary && (load || r_pendente);

    // Error flag for the value about to become active
    always_comb begin
        w_next_erro = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_next_ativo[i*4 +: 4] > 4'd9) begin
                w_next_erro = 1'b1;
            end
        end
    end

    // Scan sequencer: BLANK/SHOW alternation, dwell count, digit index and drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_blank;
            r_cnt   <= '0;
            r_d     <= 2'd0;
            r_an    <= 4'b1111;
            r_seg   <= 7'b0000000;
        end else begin
            case (r_state)
                c_st_blank: begin
                    r_state <= c_st_show;
                    r_cnt   <= '0;
                    r_an    <= ~(4'b0001 << r_d);
                    r_seg   <= w_suppress ? 7'b0000000 : DISPLAY;
                end
                default: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_blank;
                        r_an    <= 4'b1111;
                        r_d     <= r_d + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
            endcase
        end
    end

    // Double buffer: shadow capture on load, swap into active at frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ativo    <= 16'h0000;
            r_sombra   <= 16'h0000;
            r_pendente <= 1'b0;
            r_ack      <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_apply) begin
                r_ativo    <= w_next_ativo;
                r_erro     <= w_next_erro;
                r_pendente <= 1'b0;
                r_ack      <= 1'b1;
            end else if (load) begin
                r_sombra   <= valor;
                r_pendente <= 1'b1;
            end
        end
    end

    assign SEG  = r_seg;
    assign AN   = r_an;
    assign ack  = r_ack;
    assign erro = r_erro;

endmodule
`default_nettype wire

// File: doc/controlador_display.md
# controlador_display

Time-multiplexed scan controller for a 4-digit 7-segment display that shares a single `codificador` BCD-to-7-segment encoder across all digits. It holds a 16-bit packed-BCD value, steps through the digits with a programmable dwell time, and feeds each nibble to the shared encoder. It registers the encoder's segment pattern and drives one-hot active-low digit enables. New values are double-buffered and take effect only at frame boundaries, so the display never tears.

## Interface
- `DIVISOR`, default 4: SHOW cycles per digit slot; must be ≥1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: one-cycle strobe that captures `valor` into the shadow register.
- `valor`  in  16: packed BCD; `valor[3:0]` is digit 0 (least significant), `valor[15:12]` is digit 3.
- `blank_zeros`  in  1: when 1, enables leading-zero suppression.
- `BCD`  out  4: nibble sent to the shared `codificador`.
- `DISPLAY`  in  7: segment pattern returned by the `codificador` (combinational from `BCD`).
- `SEG`  out  7: registered segment drive, same polarity as `DISPLAY`.
- `AN`  out  4: digit enables, active-low, at most one low.
- `ack`  out  1: one-cycle pulse when the shadow value is applied.
- `erro`  out  1: high while the active value contains any nibble greater than 9.

## Operation
- **Registers:** `ativo[15:0]`, `sombra[15:0]`, `pendente`, a 2-bit digit index `d`, a dwell counter, and the FSM state.
- **FSM states:**
  - BLANK (1 cycle): `AN`=4'b1111; `BCD`=`ativo[d]`.
  - SHOW (`DIVISOR` cycles): `AN[d]`=0, all other bits 1.
- **Transitions:**
  - BLANK→SHOW: `SEG` ← `DISPLAY`, or ← 7'b0000000 if digit `d` is suppressed.
  - After the last SHOW cycle: `d` ← `d`+1 (wraps 3→0), then →BLANK.
- **Scan order:** 0,1,2,3,0,…
- **Digit suppression** (`SEG` forced to 0 for the slot; `AN` still pulses):
  - Nibble greater than 9.
  - `blank_zeros`=1 and the digit and all higher digits are 0. Digit 0 is never suppressed by this rule.
- **Load:** `load`=1 sets `sombra` ← `valor` and `pendente` ← 1. A load while already pending overwrites `sombra`; only one `ack` is produced.
- **Frame boundary** (edge leaving SHOW with `d`=3): if `pendente`, then `ativo` ← `sombra`, `pendente` ← 0, and `ack`=1 for the next cycle.
- **Load at the boundary edge:** `valor` bypasses the shadow and goes directly to `ativo`; `ack` fires; `pendente` ends at 0.
- **`erro`:** registered; updated whenever `ativo` is updated, as the OR over the nibbles of (nibble > 9).

## Timing
- **Reset values:** `BCD`=0, `SEG`=0, `AN`=4'b1111, `ack`=0, `erro`=0, `ativo`=0, `sombra`=0, `pendente`=0, `d`=0, state=BLANK.
- **Reset mid-frame:** outputs go to reset values immediately (asynchronous); any pending load is discarded.
- **After `rst_n` rises:**
  - First edge: BLANK, digit 0.
  - `AN[0]` goes low one cycle later.
- **Slot and frame length:** a slot is `DIVISOR`+1 cycles; a frame is 4·(`DIVISOR`+1) cycles.
- **Encoder path:** `BCD` is stable throughout BLANK and SHOW. `DISPLAY` is sampled at the BLANK→SHOW edge, giving one cycle of latency from `BCD` to `SEG`.
- **Ghosting:** `SEG` changes only on an edge where `AN` goes from 4'b1111 to one-hot.
- **Load-to-display latency:** the new value first appears in `SEG` at the digit 0 SHOW of the next frame. Worst case is frame length plus 2 cycles.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SHOW → `AN`=4'b1111, `SEG`=0, `ack`=0, `erro`=0 within the same cycle. Release → `AN` goes low on digit 0 after 1 BLANK cycle.
- **Scan timing:** `DIVISOR`=2, `valor`=16'h4321 loaded → `AN` sequence 1110,1101,1011,0111, each held 2 cycles with 1 all-high cycle between. `SEG` matches a reference `codificador` output for 1,2,3,4.
- **Double buffering:** `load` 16'h0987 at digit 1 → `SEG` keeps old digits until the frame ends. `ack` pulses exactly once, 1 cycle after the boundary edge. Next frame shows 7,8,9,0.
- **Load coincidences:**
  - Two loads (16'h1111 then 16'h2222) in the same frame → single `ack`; display shows 2222.
  - Load exactly on the boundary edge → applied immediately; `ack` asserted.
- **Leading zeros:** `valor`=16'h0042, `blank_zeros`=1 → digits 3 and 2 have `SEG`=0, digits 1 and 0 show 4 and 2. `valor`=16'h0000 → only digit 0 is lit, showing 0.
- **Invalid nibble:** `valor`=16'h12A4 → `erro`=1 after apply; digit 1 `SEG`=0; other digits show normally. A later load of 16'h1234 → `erro`=0.
